// File: rtl/ahb_rand_master.sv
// Randomised AHB-Lite master: each transaction (read/write, SINGLE/INCR4, 16-byte
// aligned address) is decoded from one 6-bit random sample and driven on the bus.
// Ports: clk/reset; rand_in, start; AHB-Lite master signals; busy/done status,
// txn_count, err_count (saturating) and rd_checksum (XOR of OKAY read beats).
module ahb_rand_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_TXN   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  rand_in,
  input  logic        start,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  output logic        busy,
  output logic        done,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count,
  output logic [31:0] rd_checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_XFER,
    S_LAST,
    S_ERR,
    S_DONE
  } state_t;

  localparam logic [15:0] NUM_TXN16    = 16'(NUM_TXN);
  localparam bit          NUM_TXN_ZERO = (NUM_TXN == 0);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        burst_q, burst_d;
  logic [31:0] base_q, base_d;
  logic [1:0]  beat_q, beat_d;
  logic        dph_vld_q, dph_vld_d;   // a data phase is outstanding on the bus
  logic        dph_wr_q, dph_wr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        done_q, done_d;
  logic [15:0] txn_q, txn_d;
  logic [7:0]  err_q, err_d;
  logic [31:0] chk_q, chk_d;

  logic [31:0] addr_cur;
  logic        err_now;
  logic        complete;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      burst_q   <= 1'b0;
      base_q    <= '0;
      beat_q    <= '0;
      dph_vld_q <= 1'b0;
      dph_wr_q  <= 1'b0;
      hwdata_q  <= '0;
      done_q    <= 1'b0;
      txn_q     <= '0;
      err_q     <= '0;
      chk_q     <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      burst_q   <= burst_d;
      base_q    <= base_d;
      beat_q    <= beat_d;
      dph_vld_q <= dph_vld_d;
      dph_wr_q  <= dph_wr_d;
      hwdata_q  <= hwdata_d;
      done_q    <= done_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
      chk_q     <= chk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    burst_d   = burst_q;
    base_d    = base_q;
    beat_d    = beat_q;
    dph_vld_d = dph_vld_q;
    dph_wr_d  = dph_wr_q;
    hwdata_d  = hwdata_q;
    done_d    = done_q;
    txn_d     = txn_q;
    err_d     = err_q;
    chk_d     = chk_q;
    complete  = 1'b0;
    HADDR     = '0;
    HTRANS    = 2'b00;
    HWRITE    = 1'b0;
    HBURST    = 3'b000;

    addr_cur = base_q + {28'd0, beat_q, 2'b00};
    // First cycle of a two-cycle ERROR response: the slave holds HREADY low.
    err_now  = dph_vld_q && HRESP && !HREADY;

    // Data phase retires whenever HREADY is high; only OKAY reads feed the checksum.
    if (dph_vld_q && HREADY) begin
      dph_vld_d = 1'b0;
      if (!dph_wr_q && !HRESP) begin
        chk_d = chk_q ^ HRDATA;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DECIDE;
          done_d  = 1'b0;
          txn_d   = '0;
          err_d   = '0;
          chk_d   = '0;
        end
      end
      S_DECIDE: begin
        write_d = rand_in[0];
        burst_d = rand_in[1];
        // 16-byte alignment keeps an INCR4 inside any 1 KB boundary.
        base_d  = BASE_ADDR + {24'd0, rand_in[5:2], 4'b0000};
        beat_d  = 2'd0;
        state_d = S_XFER;
      end
      S_XFER: begin
        HADDR  = addr_cur;
        HTRANS = (beat_q == 2'd0) ? 2'b10 : 2'b11;
        HWRITE = write_q;
        HBURST = burst_q ? 3'b011 : 3'b000;
        if (err_now) begin
          // Remaining beats are cancelled; address phase drops to IDLE next cycle.
          state_d = S_ERR;
        end else if (HREADY) begin
          dph_vld_d = 1'b1;
          dph_wr_d  = write_q;
          if (write_q) begin
            hwdata_d = addr_cur ^ 32'hA5A5_A5A5;
          end
          if (beat_q == (burst_q ? 2'd3 : 2'd0)) begin
            state_d = S_LAST;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      S_LAST: begin
        if (err_now) begin
          state_d = S_ERR;
        end else if (HREADY) begin
          complete = 1'b1;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          complete = 1'b1;
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      txn_d = txn_q + 16'd1;
      if (!NUM_TXN_ZERO && (txn_d == NUM_TXN16)) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = S_DECIDE;
      end
    end
  end

  assign HSIZE       = 3'b010;
  assign HWDATA      = hwdata_q;
  assign busy        = (state_q == S_DECIDE) || (state_q == S_XFER) ||
                       (state_q == S_LAST)   || (state_q == S_ERR);
  assign done        = done_q;
  assign txn_count   = txn_q;
  assign err_count   = err_q;
  assign rd_checksum = chk_q;

endmodule

// File: tb/tb_ahb_rand_master.sv
module tb_ahb_rand_master;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  burst;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  rand_in;
  logic [5:0]  rand_dir;
  logic [5:0]  lfsr;
  logic        lfsr_run;
  logic        use_lfsr;
  logic        start, start2;
  logic        HREADY, HRESP;
  logic [31:0] HRDATA;

  logic [31:0] haddr, hwdata, rd_checksum;
  logic [1:0]  htrans;
  logic        hwrite, busy, done;
  logic [2:0]  hsize, hburst;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  logic [31:0] haddr2, hwdata2, rd_checksum2;
  logic [1:0]  htrans2;
  logic        hwrite2, busy2, done2;
  logic [2:0]  hsize2, hburst2;
  logic [15:0] txn_count2;
  logic [7:0]  err_count2;

  int    checks = 0;
  int    errors = 0;
  logic  sel2 = 1'b0;
  beat_t exp_q[$];

  assign rand_in = use_lfsr ? lfsr : rand_dir;

  always #5 clk = ~clk;

  ahb_rand_master #(.BASE_ADDR(32'h0000_0000), .NUM_TXN(1)) u_dut (
    .clk(clk), .reset(reset), .rand_in(rand_in), .start(start),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .busy(busy), .done(done),
    .txn_count(txn_count), .err_count(err_count), .rd_checksum(rd_checksum)
  );

  ahb_rand_master #(.BASE_ADDR(32'h0000_0000), .NUM_TXN(3)) u_dut3 (
    .clk(clk), .reset(reset), .rand_in(rand_in), .start(start2),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HADDR(haddr2), .HTRANS(htrans2), .HWRITE(hwrite2), .HSIZE(hsize2),
    .HBURST(hburst2), .HWDATA(hwdata2), .busy(busy2), .done(done2),
    .txn_count(txn_count2), .err_count(err_count2), .rd_checksum(rd_checksum2)
  );

  // Upstream 6-bit LFSR stage: advances on the falling edge.
  initial begin
    lfsr = 6'b000001;
    lfsr_run = 1'b0;
    forever begin
      @(negedge clk);
      if (lfsr_run) lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    end
  end

  // Bus monitor: pops the expected beat on every accepted address phase and
  // checks write data when the matching OKAY data phase completes.
  initial begin : monitor
    logic        mon_dph;
    logic        mon_wr;
    logic [31:0] mon_wd;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_trans;
    logic        m_write;
    logic [2:0]  m_burst;
    beat_t       e;
    mon_dph = 1'b0;
    mon_wr  = 1'b0;
    mon_wd  = '0;
    forever begin
      @(negedge clk);
      m_addr  = sel2 ? haddr2  : haddr;
      m_wdata = sel2 ? hwdata2 : hwdata;
      m_trans = sel2 ? htrans2 : htrans;
      m_write = sel2 ? hwrite2 : hwrite;
      m_burst = sel2 ? hburst2 : hburst;
      if (reset) begin
        mon_dph = 1'b0;
      end else begin
        if (mon_dph && HREADY) begin
          if (mon_wr && !HRESP) begin
            checks++;
            if (m_wdata !== mon_wd) begin
              errors++;
              $display("FAIL hwdata: got %h expected %h", m_wdata, mon_wd);
            end
          end
          mon_dph = 1'b0;
        end
        if (HREADY && m_trans[1]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got addr %h trans %b, expected no beat", m_addr, m_trans);
          end else begin
            e = exp_q.pop_front();
            if (m_addr !== e.addr || m_trans !== e.trans || m_write !== e.write || m_burst !== e.burst) begin
              errors++;
              $display("FAIL beat: got addr %h trans %b wr %b burst %b expected addr %h trans %b wr %b burst %b",
                       m_addr, m_trans, m_write, m_burst, e.addr, e.trans, e.write, e.burst);
            end
            mon_dph = 1'b1;
            mon_wr  = e.write;
            mon_wd  = e.addr ^ 32'hA5A5_A5A5;
          end
        end
      end
    end
  end

  task automatic push_beat(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] b);
    beat_t e;
    e.addr = a; e.trans = t; e.write = w; e.burst = b;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rdy, input logic resp, input logic [31:0] rd);
    @(posedge clk);
    #1;
    HREADY = rdy;
    HRESP  = resp;
    HRDATA = rd;
  endtask

  // Returns 1 ns after the edge that samples start: DUT is in its decode cycle.
  task automatic pulse_start;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; use_lfsr = 1'b0; rand_dir = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (htrans !== 2'b00 || haddr !== 32'h0 || hwrite !== 1'b0 || hburst !== 3'b000) begin
      errors++;
      $display("FAIL reset_bus: got trans %b addr %h wr %b burst %b expected 00/0/0/000", htrans, haddr, hwrite, hburst);
    end
    checks++;
    if (hwdata !== 32'h0 || hsize !== 3'b010) begin
      errors++;
      $display("FAIL reset_wdata_size: got %h/%b expected 0/010", hwdata, hsize);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got busy %b done %b expected 0 0", busy, done);
    end
    checks++;
    if (txn_count !== 16'h0 || err_count !== 8'h0 || rd_checksum !== 32'h0) begin
      errors++;
      $display("FAIL reset_counters: got %h %h %h expected 0 0 0", txn_count, err_count, rd_checksum);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single_write;
    rand_dir = 6'b000101;
    push_beat(32'h10, 2'b10, 1'b1, 3'b000);
    pulse_start();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || htrans !== 2'b00) begin
      errors++;
      $display("FAIL decide_cycle: got busy %b trans %b expected 1 00", busy, htrans);
    end
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (htrans !== 2'b10 || haddr !== 32'h10 || hwrite !== 1'b1 || hburst !== 3'b000) begin
      errors++;
      $display("FAIL first_nonseq: got trans %b addr %h wr %b burst %b expected 10/00000010/1/000", htrans, haddr, hwrite, hburst);
    end
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (hwdata !== 32'hA5A5_A5B5 || htrans !== 2'b00) begin
      errors++;
      $display("FAIL single_wdata: got wdata %h trans %b expected a5a5a5b5 00", hwdata, htrans);
    end
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || txn_count !== 16'd1) begin
      errors++;
      $display("FAIL single_done: got done %b busy %b txn %0d expected 1 0 1", done, busy, txn_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_leftover: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_incr4_read;
    logic [31:0] exp_chk;
    exp_chk = '0;
    rand_dir = 6'b111010;
    for (int i = 0; i < 4; i++) push_beat(32'hE0 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, 1'b0, 3'b011);
    pulse_start();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || txn_count !== 16'd0) begin
      errors++;
      $display("FAIL start_clears: got done %b txn %0d expected 0 0", done, txn_count);
    end
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'(i + 1));
      exp_chk ^= 32'(i + 1);
    end
    @(negedge clk);
    checks++;
    if (htrans !== 2'b00) begin
      errors++;
      $display("FAIL incr4_last_idle: got trans %b expected 00", htrans);
    end
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || txn_count !== 16'd1 || rd_checksum !== exp_chk) begin
      errors++;
      $display("FAIL incr4_read: got done %b txn %0d chk %h expected 1 1 %h", done, txn_count, rd_checksum, exp_chk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL incr4_leftover: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_wait_states;
    bit          rdy_t [8];
    logic [31:0] rdd_t [8];
    logic [31:0] exp_chk;
    rdy_t = '{1, 1, 0, 0, 0, 1, 1, 1};
    rdd_t = '{0, 1, 2, 2, 2, 2, 3, 4};
    exp_chk = '0;
    rand_dir = 6'b111010;
    for (int i = 0; i < 4; i++) push_beat(32'hE0 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, 1'b0, 3'b011);
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      drive(rdy_t[c], 1'b0, rdd_t[c]);
      if (c >= 1 && rdy_t[c]) exp_chk ^= rdd_t[c];
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        checks++;
        if (haddr !== 32'hE8 || htrans !== 2'b11) begin
          errors++;
          $display("FAIL wait_hold c%0d: got addr %h trans %b expected 000000e8 11", c, haddr, htrans);
        end
      end
    end
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || txn_count !== 16'd1 || rd_checksum !== exp_chk) begin
      errors++;
      $display("FAIL wait_result: got done %b txn %0d chk %h expected 1 1 %h", done, txn_count, rd_checksum, exp_chk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wait_leftover: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_error(input bit wr);
    logic [31:0] exp_chk;
    exp_chk = wr ? 32'h0 : 32'h7;
    rand_dir = wr ? 6'b111011 : 6'b111010;
    push_beat(32'hE0, 2'b10, wr, 3'b011);
    push_beat(32'hE4, 2'b11, wr, 3'b011);
    pulse_start();
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h7);
    drive(1'b0, 1'b1, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (htrans !== 2'b00) begin
      errors++;
      $display("FAIL err_idle wr=%0d: got trans %b expected 00", wr, htrans);
    end
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (err_count !== 8'd1 || txn_count !== 16'd1 || done !== 1'b1 || rd_checksum !== exp_chk) begin
      errors++;
      $display("FAIL err_result wr=%0d: got err %0d txn %0d done %b chk %h expected 1 1 1 %h",
               wr, err_count, txn_count, done, rd_checksum, exp_chk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL err_leftover wr=%0d: got %0d beats pending expected 0", wr, exp_q.size());
    end
  endtask

  task automatic test_lfsr_run;
    logic [5:0]  r;
    logic [31:0] a;
    int          n;
    int          next_dec;
    sel2 = 1'b1;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    @(posedge clk);
    #1;
    lfsr = 6'b000001;
    lfsr_run = 1'b1;
    use_lfsr = 1'b1;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    n = 0;
    next_dec = 1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      if (n < 3 && c == next_dec) begin
        r = lfsr;
        a = {24'd0, r[5:2], 4'b0000};
        for (int b = 0; b < (r[1] ? 4 : 1); b++)
          push_beat(a + 32'(4 * b), (b == 0) ? 2'b10 : 2'b11, r[0], r[1] ? 3'b011 : 3'b000);
        next_dec = c + (r[1] ? 6 : 3);
        n++;
      end
      #1;
      start2 = (c == 4);
      if (c == 5) begin
        checks++;
        if (busy2 !== 1'b1) begin
          errors++;
          $display("FAIL lfsr_busy: got %b expected 1", busy2);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || txn_count2 !== 16'd3) begin
      errors++;
      $display("FAIL lfsr_done: got done %b busy %b txn %0d expected 1 0 3", done2, busy2, txn_count2);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lfsr_leftover: got %0d beats pending expected 0", exp_q.size());
    end
    lfsr_run = 1'b0;
    use_lfsr = 1'b0;
    sel2 = 1'b0;
  endtask

  task automatic test_reset_mid;
    rand_dir = 6'b111010;
    for (int i = 0; i < 4; i++) push_beat(32'hE0 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, 1'b0, 3'b011);
    pulse_start();
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h5);
    drive(1'b1, 1'b0, 32'h6);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (htrans !== 2'b00 || haddr !== 32'h0 || hwrite !== 1'b0 || hburst !== 3'b000 || hwdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_bus: got trans %b addr %h wr %b burst %b wdata %h expected all zero", htrans, haddr, hwrite, hburst, hwdata);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || txn_count !== 16'd0 || rd_checksum !== 32'h0) begin
      errors++;
      $display("FAIL midreset_status: got busy %b done %b txn %0d chk %h expected 0 0 0 0", busy, done, txn_count, rd_checksum);
    end
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    rand_dir = 6'b000101;
    push_beat(32'h10, 2'b10, 1'b1, 3'b000);
    pulse_start();
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || txn_count !== 16'd1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL after_reset_run: got done %b txn %0d err %0d expected 1 1 0", done, txn_count, err_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_leftover: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr4_read();
    test_wait_states();
    test_error(1'b1);
    test_error(1'b0);
    test_lfsr_run();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
